// File: rtl/uart_time_rx.sv
// UART 8N1 receiver with "YYMMDDhhmmss"+CR/LF time-set parser; one-cycle load strobe on commit.
// Optional build macro RANGE_CHECK_EN rejects out-of-range calendar/time fields at commit.
module uart_time_rx #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [6:0] Year,
    output logic [6:0] Month,
    output logic [6:0] Day,
    output logic [6:0] Hour,
    output logic [6:0] Min,
    output logic [6:0] Sec,
    output logic       set_valid,
    output logic       frame_err
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t          state, state_nx;
    logic            rx_s1, rx_s2;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic            wait_high;
    logic            sample_tick;
    logic            byte_valid;
    logic            stop_err;

    logic [3:0]      digits [12];
    logic [3:0]      idx;
    logic            is_digit;
    logic            is_term;
    logic [6:0]      y_n, mo_n, d_n, h_n, mi_n, s_n;
    logic            range_ok;

    function automatic logic [6:0] to_bin(input logic [3:0] t, input logic [3:0] o);
        return 7'(t) * 7'd10 + 7'(o);
    endfunction

    always_comb begin
        state_nx    = state;
        sample_tick = 1'b0;
        byte_valid  = 1'b0;
        stop_err    = 1'b0;
        case (state)
            S_IDLE:  if (!rx_s2 && !wait_high) state_nx = S_START;
            S_START: if (cnt == HALF) state_nx = rx_s2 ? S_IDLE : S_DATA;
            S_DATA: begin
                if (cnt == LAST) begin
                    sample_tick = 1'b1;
                    if (bit_idx == 3'd7) state_nx = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt == LAST) begin
                    state_nx   = S_IDLE;
                    byte_valid = rx_s2;
                    stop_err   = !rx_s2;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            wait_high <= 1'b0;
        end else begin
            rx_s1 <= uart_rx;
            rx_s2 <= rx_s1;
            state <= state_nx;
            if (state_nx != state || sample_tick)
                cnt <= '0;
            else if (state != S_IDLE)
                cnt <= cnt + 1'b1;
            if (state == S_START)
                bit_idx <= '0;
            else if (sample_tick)
                bit_idx <= bit_idx + 1'b1;
            if (sample_tick)
                shift <= {rx_s2, shift[7:1]};
            // A low stop bit may be a break; hold off restart until the line idles high.
            if (stop_err)
                wait_high <= 1'b1;
            else if (state == S_IDLE && rx_s2)
                wait_high <= 1'b0;
        end
    end

    always_comb begin
        is_digit = (shift >= 8'h30) && (shift <= 8'h39);
        is_term  = (shift == 8'h0D) || (shift == 8'h0A);
        y_n  = to_bin(digits[0],  digits[1]);
        mo_n = to_bin(digits[2],  digits[3]);
        d_n  = to_bin(digits[4],  digits[5]);
        h_n  = to_bin(digits[6],  digits[7]);
        mi_n = to_bin(digits[8],  digits[9]);
        s_n  = to_bin(digits[10], digits[11]);
`ifdef RANGE_CHECK_EN
        range_ok = (mo_n >= 7'd1) && (mo_n <= 7'd12) &&
                   (d_n  >= 7'd1) && (d_n  <= 7'd31) &&
                   (h_n  <= 7'd23) && (mi_n <= 7'd59) && (s_n <= 7'd59);
`else
        range_ok = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            Year      <= '0;
            Month     <= '0;
            Day       <= '0;
            Hour      <= '0;
            Min       <= '0;
            Sec       <= '0;
            set_valid <= 1'b0;
            frame_err <= 1'b0;
            for (int unsigned i = 0; i < 12; i++) digits[i] <= '0;
        end else begin
            set_valid <= 1'b0;
            frame_err <= 1'b0;
            if (stop_err) begin
                frame_err <= 1'b1;
                idx       <= '0;
            end else if (byte_valid) begin
                if (is_digit) begin
                    if (idx == 4'd12) begin
                        frame_err <= 1'b1;
                        idx       <= '0;
                    end else begin
                        digits[idx] <= shift[3:0];
                        idx         <= idx + 1'b1;
                    end
                end else if (is_term) begin
                    // Terminator with no digits pending is a blank line or the LF of CRLF.
                    if (idx == 4'd12) begin
                        idx <= '0;
                        if (range_ok) begin
                            Year      <= y_n;
                            Month     <= mo_n;
                            Day       <= d_n;
                            Hour      <= h_n;
                            Min       <= mi_n;
                            Sec       <= s_n;
                            set_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else if (idx != 4'd0) begin
                        frame_err <= 1'b1;
                        idx       <= '0;
                    end
                end else begin
                    frame_err <= 1'b1;
                    idx       <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_time_rx.sv
// Self-checking bench for uart_time_rx: serial stimulus, parser model feeding an expected-event queue.
module tb_uart_time_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_rx = 1'b1;
    logic [6:0] Year, Month, Day, Hour, Min, Sec;
    logic       set_valid, frame_err;

    typedef struct {
        bit               is_set;
        logic [5:0][6:0]  f;
    } ev_t;

    ev_t             exp_q[$];
    logic [5:0][6:0] held;
    logic [3:0]      mdig [12];
    int              midx;
    int              checks = 0;
    int              passed = 0;
    int              set_seen = 0;
    int              err_seen = 0;
    int              s0, e0;

    uart_time_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx),
        .Year(Year), .Month(Month), .Day(Day), .Hour(Hour), .Min(Min), .Sec(Sec),
        .set_valid(set_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // Scoreboard: every strobe pops one expected event.
    always @(negedge clk) begin
        ev_t e;
        logic [5:0][6:0] act;
        if (!rst && (set_valid || frame_err)) begin
            act[0] = Year; act[1] = Month; act[2] = Day;
            act[3] = Hour; act[4] = Min;   act[5] = Sec;
            if (set_valid) set_seen++;
            if (frame_err) err_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_strobe: set_valid=%0b frame_err=%0b, required no strobe",
                         set_valid, frame_err);
            end else begin
                e = exp_q.pop_front();
                if (set_valid === e.is_set && frame_err === !e.is_set && act === e.f)
                    passed++;
                else
                    $display("FAIL strobe: set_valid=%0b frame_err=%0b fields=%h, required set_valid=%0b fields=%h",
                             set_valid, frame_err, act, e.is_set, e.f);
            end
        end
    end

    task automatic push_err();
        ev_t e;
        e.is_set = 1'b0;
        e.f      = held;
        exp_q.push_back(e);
    endtask

    task automatic model_byte(input logic [7:0] b);
        ev_t e;
        logic [5:0][6:0] f;
        bit ok;
        if (b >= 8'h30 && b <= 8'h39) begin
            if (midx == 12) begin
                push_err();
                midx = 0;
            end else begin
                mdig[midx] = b[3:0];
                midx++;
            end
        end else if (b == 8'h0D || b == 8'h0A) begin
            if (midx == 12) begin
                for (int k = 0; k < 6; k++) f[k] = 7'(mdig[2*k] * 10 + mdig[2*k+1]);
                ok = 1'b1;
`ifdef RANGE_CHECK_EN
                ok = (f[1] >= 1) && (f[1] <= 12) && (f[2] >= 1) && (f[2] <= 31) &&
                     (f[3] <= 23) && (f[4] <= 59) && (f[5] <= 59);
`endif
                if (ok) begin
                    held     = f;
                    e.is_set = 1'b1;
                    e.f      = f;
                    exp_q.push_back(e);
                end else begin
                    push_err();
                end
                midx = 0;
            end else if (midx != 0) begin
                push_err();
                midx = 0;
            end
        end else begin
            push_err();
            midx = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk) uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            model_byte(s[i]);
            send_byte(s[i], 1'b1);
        end
        repeat (4 * CPB) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        held = '0;
        midx = 0;
        repeat (4) @(negedge clk);
        checks++;
        if ({Year, Month, Day, Hour, Min, Sec} !== 42'd0)
            $display("FAIL reset_fields: got %h, required 0", {Year, Month, Day, Hour, Min, Sec});
        else passed++;
        checks++;
        if ({set_valid, frame_err} !== 2'b00)
            $display("FAIL reset_strobes: got set_valid=%0b frame_err=%0b, required 0 0", set_valid, frame_err);
        else passed++;
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic();
        s0 = set_seen; e0 = err_seen;
        send_str("240315134507\r");
        checks++;
        if (exp_q.size() != 0) $display("FAIL basic_pending: %0d events missing, required 0", exp_q.size());
        else passed++;
        checks++;
        if (set_seen - s0 != 1 || err_seen != e0)
            $display("FAIL basic_counts: set=%0d err=%0d, required set=1 err=0", set_seen - s0, err_seen - e0);
        else passed++;
        checks++;
        if ({Year, Month, Day, Hour, Min, Sec} !== {7'd24, 7'd3, 7'd15, 7'd13, 7'd45, 7'd7})
            $display("FAIL basic_fields: got %0d %0d %0d %0d %0d %0d, required 24 3 15 13 45 7",
                     Year, Month, Day, Hour, Min, Sec);
        else passed++;
    endtask

    task automatic test_crlf();
        s0 = set_seen; e0 = err_seen;
        send_str("251231235959\r");
        send_str("\r\n");
        checks++;
        if (set_seen - s0 != 1 || err_seen != e0 || exp_q.size() != 0)
            $display("FAIL crlf_counts: set=%0d err=%0d pending=%0d, required set=1 err=0 pending=0",
                     set_seen - s0, err_seen - e0, exp_q.size());
        else passed++;
        checks++;
        if ({Year, Month, Day, Hour, Min, Sec} !== {7'd25, 7'd12, 7'd31, 7'd23, 7'd59, 7'd59})
            $display("FAIL crlf_fields: got %0d %0d %0d %0d %0d %0d, required 25 12 31 23 59 59",
                     Year, Month, Day, Hour, Min, Sec);
        else passed++;
    endtask

    task automatic test_glitch();
        s0 = set_seen; e0 = err_seen;
        @(negedge clk) uart_rx = 1'b0;
        repeat (5) @(negedge clk);
        uart_rx = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        checks++;
        if (set_seen != s0 || err_seen != e0)
            $display("FAIL glitch_quiet: set=%0d err=%0d, required 0 0", set_seen - s0, err_seen - e0);
        else passed++;
        send_str("010203040506\r");
        checks++;
        if (set_seen - s0 != 1 || exp_q.size() != 0 ||
            {Year, Month, Day, Hour, Min, Sec} !== {7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd6})
            $display("FAIL glitch_then_frame: set=%0d fields %0d %0d %0d %0d %0d %0d, required set=1 fields 1 2 3 4 5 6",
                     set_seen - s0, Year, Month, Day, Hour, Min, Sec);
        else passed++;
    endtask

    task automatic test_stop_err();
        s0 = set_seen; e0 = err_seen;
        push_err();
        midx = 0;
        send_byte(8'h31, 1'b0);
        repeat (4 * CPB) @(negedge clk);
        checks++;
        if (err_seen - e0 != 1 || set_seen != s0 || exp_q.size() != 0)
            $display("FAIL stop_err: err=%0d set=%0d pending=%0d, required err=1 set=0 pending=0",
                     err_seen - e0, set_seen - s0, exp_q.size());
        else passed++;
        send_str("991231235958\r");
        checks++;
        if ({Year, Month, Day, Hour, Min, Sec} !== {7'd99, 7'd12, 7'd31, 7'd23, 7'd59, 7'd58})
            $display("FAIL stop_err_recover: got %0d %0d %0d %0d %0d %0d, required 99 12 31 23 59 58",
                     Year, Month, Day, Hour, Min, Sec);
        else passed++;
    endtask

    task automatic test_length_errors();
        s0 = set_seen; e0 = err_seen;
        send_str("2403151345\r");
        checks++;
        if (err_seen - e0 != 1 || set_seen != s0 ||
            {Year, Month, Day, Hour, Min, Sec} !== {7'd99, 7'd12, 7'd31, 7'd23, 7'd59, 7'd58})
            $display("FAIL short_msg: err=%0d set=%0d year=%0d sec=%0d, required err=1 set=0 year=99 sec=58",
                     err_seen - e0, set_seen - s0, Year, Sec);
        else passed++;
        e0 = err_seen;
        // 13th digit errors and restarts; the trailing digit leaves idx=1 so CR errors too.
        send_str("24031513450799\r");
        checks++;
        if (err_seen - e0 != 2 || set_seen != s0 || exp_q.size() != 0)
            $display("FAIL long_msg: err=%0d set=%0d pending=%0d, required err=2 set=0 pending=0",
                     err_seen - e0, set_seen - s0, exp_q.size());
        else passed++;
    endtask

    task automatic test_range();
        s0 = set_seen; e0 = err_seen;
        send_str("241315250000\r");
`ifdef RANGE_CHECK_EN
        checks++;
        if (err_seen - e0 != 1 || set_seen != s0 ||
            {Year, Month, Day, Hour, Min, Sec} !== {7'd99, 7'd12, 7'd31, 7'd23, 7'd59, 7'd58})
            $display("FAIL range_reject: err=%0d set=%0d month=%0d hour=%0d, required err=1 set=0 month=12 hour=23",
                     err_seen - e0, set_seen - s0, Month, Hour);
        else passed++;
`else
        checks++;
        if (set_seen - s0 != 1 || err_seen != e0 ||
            {Year, Month, Day, Hour, Min, Sec} !== {7'd24, 7'd13, 7'd15, 7'd25, 7'd0, 7'd0})
            $display("FAIL range_accept: set=%0d err=%0d month=%0d hour=%0d, required set=1 err=0 month=13 hour=25",
                     set_seen - s0, err_seen - e0, Month, Hour);
        else passed++;
`endif
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        send_str("24031");
        b = 8'h35;
        @(negedge clk) uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = 1'b1;
        rst = 1'b1;
        held = '0;
        midx = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({Year, Month, Day, Hour, Min, Sec} !== 42'd0 || exp_q.size() != 0)
            $display("FAIL reset_mid_fields: got %h pending=%0d, required 0 pending=0",
                     {Year, Month, Day, Hour, Min, Sec}, exp_q.size());
        else passed++;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        s0 = set_seen; e0 = err_seen;
        send_str("000101000000\n");
        checks++;
        if (set_seen - s0 != 1 || err_seen != e0 ||
            {Year, Month, Day, Hour, Min, Sec} !== {7'd0, 7'd1, 7'd1, 7'd0, 7'd0, 7'd0})
            $display("FAIL reset_mid_frame: set=%0d err=%0d fields %0d %0d %0d %0d %0d %0d, required set=1 err=0 fields 0 1 1 0 0 0",
                     set_seen - s0, err_seen - e0, Year, Month, Day, Hour, Min, Sec);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_crlf();
        test_glitch();
        test_stop_err();
        test_length_errors();
        test_range();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
